// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver with dead-time insertion for one half-bridge leg.
// Takes the single-ended PWM bit from the SPWM stage and produces high-side and
// low-side gate commands. It inserts a programmable dead time between them,
// swallows pulses shorter than that dead time, and latches a shutdown on fault.
//
// Ports:
//   clk            system clock (same domain as pwm_in)
//   rst            asynchronous active-high reset
//   pwm_in         PWM command, 1 = high side on
//   enable         leg enable; low forces both outputs off
//   dead_time      dead time in clk cycles, 0 behaves as 1
//   fault_in       synchronous fault request, active high
//   fault_clear    release request for the fault latch
//   hs_out         high-side gate command
//   ls_out         low-side gate command
//   dt_active      both outputs held off for dead time
//   fault_latched  fault shutdown in effect
module pwm_deadtime_gen #(
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault_in,
  input  logic                fault_clear,
  output logic                hs_out,
  output logic                ls_out,
  output logic                dt_active,
  output logic                fault_latched
);

  // One-hot so every output is a bare flop: no decode glitches on gate drives.
  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StDt    = 5'b00010,
    StHsOn  = 5'b00100,
    StLsOn  = 5'b01000,
    StFault = 5'b10000
  } state_e;

  state_e              state_q, state_d;
  logic                pwm_q;
  logic                target_q, target_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (fault_in) begin
      state_d = StFault;
    end else if (!enable && (state_q != StFault)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          // enable is known high here; start with a full dead time.
          state_d  = StDt;
          target_d = pwm_q;
          cnt_d    = dead_time;
        end
        StDt: begin
          if (pwm_q != target_q) begin
            // Command changed before the dead time expired: restart toward it.
            target_d = pwm_q;
            cnt_d    = dead_time;
          end else if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = target_q ? StHsOn : StLsOn;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        StHsOn: begin
          if (!pwm_q) begin
            state_d  = StDt;
            target_d = 1'b0;
            cnt_d    = dead_time;
          end
        end
        StLsOn: begin
          if (pwm_q) begin
            state_d  = StDt;
            target_d = 1'b1;
            cnt_d    = dead_time;
          end
        end
        StFault: begin
          // fault_in is already known low on this path.
          if (fault_clear) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pwm_q    <= 1'b0;
      target_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pwm_q    <= pwm_in;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hs_out        = state_q[2];
  assign ls_out        = state_q[3];
  assign dt_active     = state_q[1];
  assign fault_latched = state_q[4];

endmodule
